spi_frame_sequencer: RTL and testbench

- Upstream feeder for the byte-wide SPI transmitter in the frequency meter.
- Captures one frequency measurement word and splits it into a byte frame: header byte, data bytes MSB first, and an optional checksum byte.
- Sends the frame one byte at a time over the transmitter's send/done/ack handshake.
- Detects a stalled transmitter with a timeout and reports frame completion or abort.

---
 rtl/spi_frame_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_sequencer.sv
// Purpose : splits one captured measurement word into a byte frame (header, data MSB first, optional checksum) for the SPI transmitter.
// Latency : capture to spi_send high is 2 cycles; between bytes, the cycle after the done fall is LOAD and SEND follows it.
// Backpressure: meas_ready is high only while idle; each byte waits for the transmitter's done rise/fall, bounded by a TIMEOUT-cycle abort.
//
// Ports:
//   clk, rst                     system clock, synchronous active-low reset
//   meas_valid/meas_ready        measurement capture handshake; meas_data is 8*DATA_BYTES bits
//   spi_send, spi_data_out       byte request (level) and the byte, held stable while spi_send is high
//   spi_send_done                transmitter done level, asynchronous to clk
//   tx_ack                       done acknowledge, feeds the transmitter's busy input
//   frame_done, timeout_err      one-cycle completion / abort pulses
//
// Build option: define SPI_FRAME_CHECKSUM_EN to append an XOR checksum byte
// (HEADER ^ all data bytes) to every frame. Without it no checksum register exists.

module spi_frame_sequencer #(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] HEADER     = 8'hA5,
    parameter int         TIMEOUT    = 2000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    meas_valid,
    input  logic [8*DATA_BYTES-1:0] meas_data,
    output logic                    meas_ready,
    output logic                    spi_send,
    output logic [7:0]              spi_data_out,
    input  logic                    spi_send_done,
    output logic                    tx_ack,
    output logic                    frame_done,
    output logic                    timeout_err
);

    localparam int DW = 8 * DATA_BYTES;

`ifdef SPI_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = DATA_BYTES + 2;
`else
    localparam int FRAME_LEN = DATA_BYTES + 1;
`endif

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    // Per-byte stall counter; it only ever needs to reach TIMEOUT-1.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] data_sr;
    logic [3:0]    byte_idx;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] tmo_next;
    logic          tmo_hit;

    // done_m/done_s form the two-flop synchroniser; done_q is the edge-detect delay.
    logic          done_m;
    logic          done_s;
    logic          done_q;
    logic          done_rise;
    logic          done_fall;

    logic [7:0]    next_byte;
    logic          next_is_data;

`ifdef SPI_FRAME_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    assign done_rise = done_s & ~done_q;
    assign done_fall = ~done_s & done_q;

    // Gating with rst keeps meas_ready low while reset is being held.
    assign meas_ready = rst && (state == S_IDLE);

    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign tmo_next = tmo_hit ? tmo_cnt : tmo_cnt + CW'(1);

    // Byte selected for the current byte_idx. Data bytes always come from the
    // top of the shift register, which is shifted once per data byte loaded.
    always_comb begin
        next_byte    = HEADER;
        next_is_data = 1'b0;
        if (byte_idx != 4'd0) begin
            next_byte    = data_sr[DW-1 -: 8];
            next_is_data = 1'b1;
        end
`ifdef SPI_FRAME_CHECKSUM_EN
        if (byte_idx == LAST_IDX) begin
            next_byte    = checksum;
            next_is_data = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            data_sr      <= '0;
            byte_idx     <= 4'd0;
            tmo_cnt      <= '0;
            done_m       <= 1'b0;
            done_s       <= 1'b0;
            done_q       <= 1'b0;
            spi_send     <= 1'b0;
            spi_data_out <= 8'h00;
            tx_ack       <= 1'b0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
            checksum     <= 8'h00;
`endif
        end else begin
            done_m      <= spi_send_done;
            done_s      <= done_m;
            done_q      <= done_s;

            // Status outputs are single-cycle pulses.
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Words offered outside IDLE are simply not taken.
                    if (meas_valid) begin
                        data_sr  <= meas_data;
                        byte_idx <= 4'd0;
`ifdef SPI_FRAME_CHECKSUM_EN
                        checksum <= 8'h00;
`endif
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    spi_data_out <= next_byte;
                    if (next_is_data) begin
                        data_sr <= data_sr << 8;
                    end
`ifdef SPI_FRAME_CHECKSUM_EN
                    // The checksum byte itself is never folded back in.
                    if (byte_idx != LAST_IDX) begin
                        checksum <= checksum ^ next_byte;
                    end
`endif
                    tmo_cnt  <= '0;
                    spi_send <= 1'b1;
                    state    <= S_SEND;
                end

                S_SEND: begin
                    // Only a fresh rising edge counts: a done level that was
                    // already high when SEND was entered is stale. A rise in
                    // the same cycle as the terminal count still wins.
                    if (done_rise) begin
                        spi_send <= 1'b0;
                        tx_ack   <= 1'b1;
                        tmo_cnt  <= tmo_next;
                        state    <= S_ACK;
                    end else if (tmo_hit) begin
                        spi_send    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end

                S_ACK: begin
                    // The counter keeps running from SEND: the budget covers
                    // the whole byte, including the transmitter's release.
                    if (done_fall) begin
                        tx_ack <= 1'b0;
                        if (byte_idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= S_LOAD;
                        end
                    end else if (tmo_hit) begin
                        tx_ack      <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end

                default: begin
                    spi_send <= 1'b0;
                    tx_ack   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Purpose : self-checking bench for spi_frame_sequencer with a frame-level reference model and a simple transmitter model.
// Latency : not applicable (bench).
// Backpressure: transmitter model drives spi_send_done in normal, dead, glitch or manual modes.

module tb_spi_frame_sequencer;

    localparam int         DATA_BYTES = 4;
    localparam logic [7:0] HDR        = 8'hA5;
    localparam int         TMO        = 100;

`ifdef SPI_FRAME_CHECKSUM_EN
    localparam int          NB   = 6;
    localparam logic [63:0] EXP1 = 64'hA512345678AD;
    localparam logic [63:0] EXP3 = 64'hA5DEADBEEF87;
    localparam logic [63:0] EXP4 = 64'hA500FF00FFA5;
    localparam logic [63:0] EXP5 = 64'hA501020304A1;
    localparam logic [63:0] EXP6 = 64'hA5A0B1C2D3A5;
`else
    localparam int          NB   = 5;
    localparam logic [63:0] EXP1 = 64'hA512345678;
    localparam logic [63:0] EXP3 = 64'hA5DEADBEEF;
    localparam logic [63:0] EXP4 = 64'hA500FF00FF;
    localparam logic [63:0] EXP5 = 64'hA501020304;
    localparam logic [63:0] EXP6 = 64'hA5A0B1C2D3;
`endif

    localparam int M_NORMAL = 0;
    localparam int M_DEAD   = 1;
    localparam int M_GLITCH = 2;
    localparam int M_MANUAL = 3;

    logic                    clk;
    logic                    rst;
    logic                    meas_valid;
    logic [8*DATA_BYTES-1:0] meas_data;
    logic                    meas_ready;
    logic                    spi_send;
    logic [7:0]              spi_data_out;
    logic                    spi_send_done;
    logic                    tx_ack;
    logic                    frame_done;
    logic                    timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    int xmt_mode    = M_MANUAL;
    bit manual_done = 1'b0;

    // Frame-level reference model state.
    bit         m_active = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] sent_log[$];
    int         n_sent = 0;
    int         n_fd   = 0;
    int         n_to   = 0;
    logic       prev_send = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_fd   = 1'b0;
    logic       prev_to   = 1'b0;

    spi_frame_sequencer #(
        .DATA_BYTES (DATA_BYTES),
        .HEADER     (HDR),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .meas_valid    (meas_valid),
        .meas_data     (meas_data),
        .meas_ready    (meas_ready),
        .spi_send      (spi_send),
        .spi_data_out  (spi_data_out),
        .spi_send_done (spi_send_done),
        .tx_ack        (tx_ack),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [63:0] pack_log();
        logic [63:0] p = 64'd0;
        foreach (sent_log[i]) p = {p[55:0], sent_log[i]};
        return p;
    endfunction

    // Transmitter model: raises done 50 cycles into spi_send, drops it 20
    // cycles into tx_ack (normal); never answers (dead); one-cycle done
    // pulse (glitch); or follows manual_done.
    initial begin : xmt
        int cnt;
        cnt = 0;
        spi_send_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (xmt_mode)
                M_NORMAL: begin
                    if (!spi_send_done) begin
                        if (spi_send) begin
                            cnt++;
                            if (cnt == 50) begin spi_send_done = 1'b1; cnt = 0; end
                        end else cnt = 0;
                    end else begin
                        if (tx_ack) begin
                            cnt++;
                            if (cnt == 20) begin spi_send_done = 1'b0; cnt = 0; end
                        end else cnt = 0;
                    end
                end
                M_GLITCH: begin
                    if (spi_send_done) spi_send_done = 1'b0;
                    else if (spi_send) begin
                        cnt++;
                        if (cnt == 50) begin spi_send_done = 1'b1; cnt = 0; end
                    end else cnt = 0;
                end
                M_DEAD: begin spi_send_done = 1'b0; cnt = 0; end
                default: begin spi_send_done = manual_done; cnt = 0; end
            endcase
        end
    end

    // Model update: a word is taken whenever the sequencer is idle, i.e. not
    // mid-frame or on the cycle its end pulse shows it has returned to idle.
    always @(posedge clk) begin
        if (!rst) begin
            m_active = 1'b0;
            exp_q.delete();
        end else begin
            if (frame_done || timeout_err) begin
                m_active = 1'b0;
                exp_q.delete();
            end
            if (meas_valid && !m_active) begin
                logic [7:0] x;
                m_active = 1'b1;
                exp_q.delete();
                exp_q.push_back(HDR);
                x = HDR;
                for (int b = DATA_BYTES - 1; b >= 0; b--) begin
                    exp_q.push_back(meas_data[b*8 +: 8]);
                    x = x ^ meas_data[b*8 +: 8];
                end
`ifdef SPI_FRAME_CHECKSUM_EN
                exp_q.push_back(x);
`endif
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_ready;
        exp_ready = rst && (!m_active || frame_done || timeout_err);
        check("meas_ready", 64'(meas_ready), 64'(exp_ready));
        if (spi_send || tx_ack)
            check("send_ack_exclusive", 64'(spi_send & tx_ack), 64'd0);
        if (spi_send && !prev_send) begin
            check("byte_queued", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                check("byte_value", 64'(spi_data_out), 64'(exp_q.pop_front()));
            sent_log.push_back(spi_data_out);
            n_sent++;
        end
        if (spi_send && prev_send)
            check("data_held", 64'(spi_data_out), 64'(prev_data));
        if (frame_done) begin
            check("frame_done_all_sent", 64'(exp_q.size()), 64'd0);
            check("frame_done_width", 64'(prev_fd), 64'd0);
            n_fd++;
        end
        if (timeout_err) begin
            check("timeout_width", 64'(prev_to), 64'd0);
            n_to++;
        end
        prev_send = spi_send;
        prev_data = spi_data_out;
        prev_fd   = frame_done;
        prev_to   = timeout_err;
    end

    // sel: 0 frame_done, 1 timeout_err, 2 spi_send, 3 tx_ack, 4 n_sent >= arg
    task automatic wait_for(input int sel, input int arg, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            case (sel)
                0: seen = frame_done;
                1: seen = timeout_err;
                2: seen = spi_send;
                3: seen = tx_ack;
                default: seen = (n_sent >= arg);
            endcase
            if (seen) break;
        end
    endtask

    task automatic capture(input logic [31:0] d);
        meas_data  = d;
        meas_valid = 1'b1;
        @(posedge clk); #1;
        meas_valid = 1'b0;
    endtask

    task automatic clear_log();
        sent_log.delete();
        n_sent = 0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        bit seen;
        int cnt;
        int fd0;
        int to0;
        rst        = 1'b0;
        meas_valid = 1'b0;
        meas_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_meas_ready", 64'(meas_ready), 64'd0);
        check("rst_spi_send", 64'(spi_send), 64'd0);
        check("rst_tx_ack", 64'(tx_ack), 64'd0);
        check("rst_data_out", 64'(spi_data_out), 64'd0);
        check("rst_pulses", 64'({frame_done, timeout_err}), 64'd0);
        rst = 1'b1;
        #1;
        check("ready_after_release", 64'(meas_ready), 64'd1);

        // Normal frame and capture-to-send latency.
        xmt_mode = M_NORMAL;
        @(posedge clk); #1;
        clear_log();
        capture(32'h12345678);
        check("lat_load_cycle", 64'(spi_send), 64'd0);
        @(posedge clk); #1;
        check("lat_send_2cyc", 64'(spi_send), 64'd1);
        check("first_byte_header", 64'(spi_data_out), 64'hA5);
        wait_for(0, 0, 2000, seen);
        check("t1_frame_done_seen", 64'(seen), 64'd1);
        check("t1_ready", 64'(meas_ready), 64'd1);
        check("t1_bytes", pack_log(), EXP1);
        check("t1_nbytes", 64'(sent_log.size()), 64'(NB));
        @(posedge clk); #1;
        check("t1_pulse_one_cycle", 64'(frame_done), 64'd0);

        // Transmitter never answers: exactly TMO cycles of spi_send.
        xmt_mode = M_DEAD;
        clear_log();
        capture(32'hCAFEF00D);
        wait_for(2, 0, 10, seen);
        check("t2_send_seen", 64'(seen), 64'd1);
        cnt = 0;
        while (spi_send && cnt < 1000) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("t2_send_cycles", 64'(cnt), 64'(TMO));
        check("t2_timeout_pulse", 64'(timeout_err), 64'd1);
        check("t2_no_frame_done", 64'(frame_done), 64'd0);
        check("t2_idle_ready", 64'(meas_ready), 64'd1);
        check("t2_tx_ack", 64'(tx_ack), 64'd0);

        // meas_valid during byte 2 is ignored; a word right after frame_done is taken.
        xmt_mode = M_NORMAL;
        @(posedge clk); #1;
        clear_log();
        capture(32'hDEADBEEF);
        wait_for(4, 3, 1000, seen);
        check("t3_byte2_reached", 64'(seen), 64'd1);
        meas_data  = 32'h11111111;
        meas_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("t3_not_ready_midframe", 64'(meas_ready), 64'd0);
        meas_valid = 1'b0;
        wait_for(0, 0, 2000, seen);
        check("t3_frame_done_seen", 64'(seen), 64'd1);
        check("t3_bytes", pack_log(), EXP3);
        clear_log();
        capture(32'h00FF00FF);
        wait_for(0, 0, 2000, seen);
        check("t3b_frame_done_seen", 64'(seen), 64'd1);
        check("t3b_bytes", pack_log(), EXP4);

        // Reset held one cycle while in ACK of byte 3.
        @(posedge clk); #1;
        clear_log();
        capture(32'h87654321);
        wait_for(4, 4, 2000, seen);
        check("t4_byte3_reached", 64'(seen), 64'd1);
        wait_for(3, 0, 200, seen);
        check("t4_ack_reached", 64'(seen), 64'd1);
        fd0 = n_fd;
        to0 = n_to;
        rst         = 1'b0;
        xmt_mode    = M_MANUAL;
        manual_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t4_spi_send", 64'(spi_send), 64'd0);
        check("t4_tx_ack", 64'(tx_ack), 64'd0);
        check("t4_data_out", 64'(spi_data_out), 64'd0);
        check("t4_pulses", 64'({frame_done, timeout_err}), 64'd0);
        check("t4_ready", 64'(meas_ready), 64'd1);
        repeat (10) begin @(posedge clk); #1; end
        check("t4_no_frame_done", 64'(n_fd), 64'(fd0));
        check("t4_no_timeout", 64'(n_to), 64'(to0));

        // Stale done level across LOAD->SEND must not advance the byte.
        manual_done = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        clear_log();
        capture(32'h01020304);
        repeat (30) begin @(posedge clk); #1; end
        check("t5_still_sending", 64'(spi_send), 64'd1);
        check("t5_no_ack", 64'(tx_ack), 64'd0);
        check("t5_one_byte", 64'(n_sent), 64'd1);
        manual_done = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("t5_fall_no_ack", 64'(tx_ack), 64'd0);
        manual_done = 1'b1;
        wait_for(3, 0, 10, seen);
        check("t5_fresh_rise_ack", 64'(seen), 64'd1);
        manual_done = 1'b0;
        wait_for(4, 2, 20, seen);
        check("t5_next_byte", 64'(seen), 64'd1);
        xmt_mode = M_NORMAL;
        wait_for(0, 0, 2000, seen);
        check("t5_frame_done_seen", 64'(seen), 64'd1);
        check("t5_bytes", pack_log(), EXP5);

        // One-clock done glitches: each byte still advances exactly once.
        xmt_mode = M_GLITCH;
        @(posedge clk); #1;
        clear_log();
        to0 = n_to;
        capture(32'hA0B1C2D3);
        wait_for(0, 0, 2000, seen);
        check("t6_frame_done_seen", 64'(seen), 64'd1);
        check("t6_bytes", pack_log(), EXP6);
        check("t6_no_timeout", 64'(n_to), 64'(to0));

        repeat (3) begin @(posedge clk); #1; end
        check("total_frame_done", 64'(n_fd), 64'd5);
        check("total_timeouts", 64'(n_to), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
